// File: rtl/config_sequencer_if.sv
// Host-side and chain-side signals of the configuration sequencer.
// The slave modport is the sequencer's view; master is the host/chain side.
interface config_sequencer_if #(
    parameter int NUM_BLOCKS = 4,
    parameter int MAX_BYTES  = 8
);
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int LW = $clog2(MAX_BYTES + 1);

    logic          tracing_req;
    logic          start;
    logic          wr_en;
    logic [BW-1:0] wr_block;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          len_wr_en;
    logic [LW-1:0] len_data;
    logic          tracing;
    logic [7:0]    configId;
    logic [7:0]    configData;
    logic          busy;
    logic          done;
    logic          wr_err;

    modport master (
        output tracing_req, start, wr_en, wr_block, wr_addr, wr_data, len_wr_en, len_data,
        input  tracing, configId, configData, busy, done, wr_err
    );

    modport slave (
        input  tracing_req, start, wr_en, wr_block, wr_addr, wr_data, len_wr_en, len_data,
        output tracing, configId, configData, busy, done, wr_err
    );
endinterface

// File: rtl/config_sequencer.sv
// Streams per-block firmware images onto the configId/configData bus after draining the chain.
// Latency: start -> DRAIN next cycle, first byte DRAIN_CYCLES later, one byte per cycle.
// No backpressure: the chain must accept every byte; host writes while busy are dropped and flagged.
module config_sequencer #(
    parameter int         NUM_BLOCKS   = 4,
    parameter int         MAX_BYTES    = 8,
    parameter int         BASE_ID      = 0,
    parameter logic [7:0] IDLE_ID      = 8'hFF,
    parameter int         DRAIN_CYCLES = 4
) (
    input logic                clk,
    input logic                reset,
    config_sequencer_if.slave  bus
);
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SEND, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] blk, blk_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    image [NUM_BLOCKS][MAX_BYTES];
    logic [LW-1:0] len   [NUM_BLOCKS];
    logic [7:0]    id_nxt, data_nxt;
    logic          done_nxt;
    logic          found;
    logic [BW-1:0] found_blk;
    int            search_from;
    logic          accept;

    assign accept = (state == S_IDLE);

    // Lowest-numbered non-empty block at or after search_from; empty blocks are skipped entirely.
    always_comb begin
        search_from = (state == S_GAP) ? int'(blk) + 1 : 0;
        found       = 1'b0;
        found_blk   = '0;
        for (int b = NUM_BLOCKS - 1; b >= 0; b--) begin
            if (b >= search_from && len[b] != '0) begin
                found     = 1'b1;
                found_blk = BW'(b);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        blk_nxt   = blk;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN, S_GAP: begin
                if (state == S_DRAIN && int'(cnt) != DRAIN_CYCLES - 1) begin
                    cnt_nxt = cnt + CW'(1);
                end else if (found) begin
                    state_nxt = S_SEND;
                    blk_nxt   = found_blk;
                    idx_nxt   = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (int'(idx) + 1 >= int'(len[blk])) state_nxt = S_GAP;
                else                                 idx_nxt   = idx + AW'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        id_nxt   = IDLE_ID;
        data_nxt = '0;
        done_nxt = (state != S_IDLE) && (state_nxt == S_IDLE);
        if (state_nxt == S_SEND) begin
            id_nxt   = 8'(BASE_ID + int'(blk_nxt));
            data_nxt = image[blk_nxt][idx_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            blk            <= '0;
            idx            <= '0;
            cnt            <= '0;
            bus.configId   <= IDLE_ID;
            bus.configData <= '0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_nxt;
            blk            <= blk_nxt;
            idx            <= idx_nxt;
            cnt            <= cnt_nxt;
            bus.configId   <= id_nxt;
            bus.configData <= data_nxt;
            bus.done       <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_err <= 1'b0;
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                len[b] <= '0;
                for (int a = 0; a < MAX_BYTES; a++) image[b][a] <= '0;
            end
        end else begin
            if ((bus.wr_en || bus.len_wr_en) && !accept) bus.wr_err <= 1'b1;
            else if (accept && bus.start)                bus.wr_err <= 1'b0;
            if (accept && bus.wr_en && int'(bus.wr_block) < NUM_BLOCKS
                && int'(bus.wr_addr) < MAX_BYTES)
                image[bus.wr_block][bus.wr_addr] <= bus.wr_data;
            if (accept && bus.len_wr_en && int'(bus.wr_block) < NUM_BLOCKS)
                len[bus.wr_block] <= (int'(bus.len_data) > MAX_BYTES) ? LW'(MAX_BYTES)
                                                                      : bus.len_data;
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.tracing = bus.tracing_req & ~bus.busy & ~reset;
endmodule

// File: tb/tb_config_sequencer.sv
// Randomized scoreboard bench for config_sequencer: expected byte/done events are queued at start.
module tb_config_sequencer;
    localparam int         NB   = 4;
    localparam int         MB   = 8;
    localparam int         DC   = 4;
    localparam logic [7:0] IDLE = 8'hFF;

    typedef struct {
        bit         is_done;
        logic [7:0] id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    config_sequencer_if #(.NUM_BLOCKS(NB), .MAX_BYTES(MB)) bus();

    config_sequencer #(
        .NUM_BLOCKS(NB), .MAX_BYTES(MB), .BASE_ID(0), .IDLE_ID(IDLE), .DRAIN_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_img [NB][MB];
    int         m_len [NB];
    bit         m_err;
    int         busy_lo = 1;
    int         busy_hi = 0;
    exp_t       q[$];

    function automatic bit in_busy(int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < NB; b++) begin
            m_len[b] = 0;
            for (int a = 0; a < MB; a++) m_img[b][a] = 8'h00;
        end
        m_err   = 1'b0;
        busy_lo = 1;
        busy_hi = 0;
        q.delete();
    endtask

    // Expected stream: DC idle cycles, then each non-empty block's bytes followed by one gap.
    task automatic build_pass(int t);
        int   c;
        exp_t e;
        c = t + 1 + DC;
        for (int b = 0; b < NB; b++) begin
            if (m_len[b] > 0) begin
                for (int i = 0; i < m_len[b]; i++) begin
                    e.is_done = 1'b0; e.id = 8'(b); e.data = m_img[b][i]; e.cyc = c;
                    q.push_back(e);
                    c++;
                end
                c++;
            end
        end
        e.is_done = 1'b1; e.id = IDLE; e.data = 8'h00; e.cyc = c;
        q.push_back(e);
        busy_lo = t + 1;
        busy_hi = c - 1;
    endtask

    // Drives one cycle of host inputs and applies the same rules to the model.
    task automatic cycle_in(bit st, bit we, int b, int a, int d, bit le, int l);
        bus.start     = st;
        bus.wr_en     = we;
        bus.wr_block  = 2'(b);
        bus.wr_addr   = 3'(a);
        bus.wr_data   = 8'(d);
        bus.len_wr_en = le;
        bus.len_data  = 4'(l);
        if (in_busy(cyc)) begin
            if (we || le) m_err = 1'b1;
        end else begin
            if (we) m_img[b][a] = 8'(d);
            if (le) m_len[b] = (l > MB) ? MB : l;
            if (st) begin
                m_err = 1'b0;
                build_pass(cyc);
            end
        end
        tick();
        bus.start     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.len_wr_en = 1'b0;
    endtask

    task automatic wait_pass();
        int guard = 0;
        while (cyc <= busy_hi + 1 && guard < 200) begin
            tick();
            guard++;
        end
        chk("pass_timeout", int'(guard < 200), 1);
        chk("queue_drained", q.size(), 0);
        chk("wr_err_after_pass", int'(bus.wr_err), int'(m_err));
    endtask

    always @(negedge clk) begin
        if (!reset && cyc > 0) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missing_output_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            chk("busy", int'(bus.busy), int'(in_busy(cyc)));
            chk("tracing", int'(bus.tracing), int'(bus.tracing_req && !in_busy(cyc)));
            if (bus.configId != IDLE || bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {23'd0, bus.done, bus.configId}, {24'd0, IDLE});
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("out_done", int'(bus.done), int'(e.is_done));
                    if (!e.is_done) begin
                        chk("configId", int'(bus.configId), int'(e.id));
                        chk("configData", int'(bus.configData), int'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        int t;
        bus.tracing_req = 1'b1;
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.len_wr_en = 1'b0;
        bus.wr_block = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.len_data = '0;
        clear_model();
        repeat (3) tick();
        chk("rst_configId", int'(bus.configId), int'(IDLE));
        chk("rst_configData", int'(bus.configData), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wr_err", int'(bus.wr_err), 0);
        chk("rst_tracing_forced", int'(bus.tracing), 0);
        reset = 1'b0;
        tick();

        // Full block 0.
        for (int i = 0; i < MB; i++) cycle_in(0, 1, 0, i, 8'h10 + i, 0, 0);
        cycle_in(0, 0, 0, 0, 0, 1, 8);
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        wait_pass();

        // Lengths {2,0,0,3}.
        for (int i = 0; i < 3; i++) cycle_in(0, 1, 3, i, $urandom_range(0, 255), 0, 0);
        cycle_in(0, 0, 0, 0, 0, 1, 2);
        cycle_in(0, 0, 3, 0, 0, 1, 3);
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        wait_pass();

        // All lengths zero.
        cycle_in(0, 0, 0, 0, 0, 1, 0);
        cycle_in(0, 0, 3, 0, 0, 1, 0);
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        wait_pass();

        // Start and write while busy.
        cycle_in(0, 0, 0, 0, 0, 1, 8);
        t = cyc;
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        while (cyc < t + 6) tick();
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        cycle_in(0, 1, 0, 1, 8'hEE, 0, 0);
        chk("wr_err_set", int'(bus.wr_err), 1);
        wait_pass();
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        chk("wr_err_cleared", int'(bus.wr_err), 0);
        wait_pass();

        // Reset during SEND.
        t = cyc;
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        while (cyc < t + 7) tick();
        reset = 1'b1;
        clear_model();
        #1;
        chk("midrst_configId", int'(bus.configId), int'(IDLE));
        chk("midrst_tracing", int'(bus.tracing), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("postrst_done", int'(bus.done), 0);
        chk("postrst_wr_err", int'(bus.wr_err), 0);
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        wait_pass();

        // Length clamp.
        for (int i = 0; i < MB; i++) cycle_in(0, 1, 2, i, $urandom_range(0, 255), 0, 0);
        cycle_in(0, 0, 2, 0, 0, 1, 12);
        cycle_in(1, 0, 0, 0, 0, 0, 0);
        wait_pass();

        // Random passes with combined writes and a write in the start cycle.
        for (int p = 0; p < 8; p++) begin
            bus.tracing_req = 1'($urandom_range(0, 1));
            for (int w = 0; w < 6; w++)
                cycle_in(0, 1, $urandom_range(0, NB - 1), $urandom_range(0, MB - 1),
                         $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 12));
            cycle_in(1, 1, $urandom_range(0, NB - 1), $urandom_range(0, MB - 1),
                     $urandom_range(0, 255), 1, $urandom_range(0, 12));
            wait_pass();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
